// File: rtl/uart_fifo_core.sv
// UART core with a programmable 16x tick, optional parity, sticky RX error flags
// and show-ahead TX/RX FIFOs whose status outputs are all registered.

module uart_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok, pop_ok;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        push_ok = push && !full_q;
        pop_ok  = pop && !empty_q;
        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop_ok);
        level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
        head_d  = head_q;
        // The head register mirrors the entry at the post-operation read pointer;
        // a word written into an otherwise empty buffer bypasses storage.
        if (push_ok && (wptr_q == rptr_d))
            head_d = wdata;
        else if (level_d != '0)
            head_d = mem_q[rptr_d];
    end

    // NOTE: storage has no reset; the pointers and level decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= wdata;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            head_q  <= head_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign head  = head_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_write,
    output logic                 tx_full,
    output logic [LW-1:0]        tx_level,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_read,
    output logic                 rx_empty,
    output logic [LW-1:0]        rx_level,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 err_clear
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 tick;

    state_e               tx_state_q, tx_state_d;
    logic [3:0]           tx_ticks_q, tx_ticks_d;
    logic [BW-1:0]        tx_bits_q, tx_bits_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_line_q, tx_line_d;
    logic                 tx_pop, tx_load, tx_empty;
    logic [DATA_BITS-1:0] tx_head;

    logic [1:0]           rx_sync_q, rx_sync_d;
    logic                 rx_s;
    state_e               rx_state_q, rx_state_d;
    logic [3:0]           rx_ticks_q, rx_ticks_d;
    logic [BW-1:0]        rx_bits_q, rx_bits_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_word_q, rx_word_d;
    logic                 rx_par_q, rx_par_d, rx_push_q, rx_push_d, rx_full;
    logic                 frame_set, parity_set;
    logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        tick      = (div_cnt_q >= div);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end

    // Bit states last 16 ticks; the 4-bit tick count wraps to 0 at each bit boundary.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_ticks_d = tx_ticks_q;
        tx_bits_d  = tx_bits_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_load    = 1'b0;
        if (tick) begin
            tx_ticks_d = tx_ticks_q + 4'd1;
            case (tx_state_q)
                S_IDLE: begin
                    tx_ticks_d = '0;
                    tx_load    = !tx_empty;
                end
                S_START: if (tx_ticks_q == 4'd15) begin
                    tx_state_d = S_DATA;
                    tx_line_d  = tx_shift_q[0];
                    tx_bits_d  = '0;
                end
                S_DATA: if (tx_ticks_q == 4'd15) begin
                    if (tx_bits_q == BIT_LAST) begin
                        tx_state_d = parity_en ? S_PAR : S_STOP;
                        tx_line_d  = parity_en ? tx_par_q : 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                        tx_bits_d  = tx_bits_q + BW'(1);
                    end
                end
                S_PAR: if (tx_ticks_q == 4'd15) begin
                    tx_state_d = S_STOP;
                    tx_line_d  = 1'b1;
                end
                S_STOP: if (tx_ticks_q == 4'd15) begin
                    tx_load    = !tx_empty;
                    tx_state_d = S_IDLE;
                    tx_line_d  = 1'b1;
                end
                default: tx_state_d = S_IDLE;
            endcase
        end
        if (tx_load) begin
            tx_state_d = S_START;
            tx_ticks_d = '0;
            tx_shift_d = tx_head;
            tx_par_d   = (^tx_head) ^ parity_odd;
            tx_line_d  = 1'b0;
        end
        tx_pop = tx_load;
    end

    // Start is confirmed 8 ticks after detection; later bits are sampled every 16 ticks.
    always_comb begin
        rx_sync_d  = {rx_sync_q[0], uart_rx};
        rx_s       = rx_sync_q[1];
        rx_state_d = rx_state_q;
        rx_ticks_d = rx_ticks_q;
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_word_d  = rx_word_q;
        rx_push_d  = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        if (tick) begin
            rx_ticks_d = rx_ticks_q + 4'd1;
            case (rx_state_q)
                S_IDLE: begin
                    rx_ticks_d = '0;
                    if (!rx_s)
                        rx_state_d = S_START;
                end
                S_START: if (rx_ticks_q == 4'd7) begin
                    rx_ticks_d = '0;
                    rx_bits_d  = '0;
                    rx_state_d = rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_ticks_q == 4'd15) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bits_q == BIT_LAST)
                        rx_state_d = parity_en ? S_PAR : S_STOP;
                    else
                        rx_bits_d = rx_bits_q + BW'(1);
                end
                S_PAR: if (rx_ticks_q == 4'd15) begin
                    rx_par_d   = rx_s;
                    rx_state_d = S_STOP;
                end
                S_STOP: if (rx_ticks_q == 4'd15) begin
                    rx_state_d = S_IDLE;
                    if (!rx_s) begin
                        frame_set = 1'b1;
                    end else begin
                        rx_push_d  = 1'b1;
                        rx_word_d  = rx_shift_q;
                        parity_set = parity_en && (rx_par_q != ((^rx_shift_q) ^ parity_odd));
                    end
                end
                default: rx_state_d = S_IDLE;
            endcase
        end
        frame_err_d  = frame_set  || (frame_err_q  && !err_clear);
        parity_err_d = parity_set || (parity_err_q && !err_clear);
        overrun_d    = (rx_push_q && rx_full) || (overrun_q && !err_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q    <= '0;
            tx_state_q   <= S_IDLE;
            tx_ticks_q   <= '0;
            tx_bits_q    <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_line_q    <= 1'b1;
            rx_sync_q    <= 2'b11;
            rx_state_q   <= S_IDLE;
            rx_ticks_q   <= '0;
            rx_bits_q    <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_word_q    <= '0;
            rx_push_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            tx_state_q   <= tx_state_d;
            tx_ticks_q   <= tx_ticks_d;
            tx_bits_q    <= tx_bits_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            tx_line_q    <= tx_line_d;
            rx_sync_q    <= rx_sync_d;
            rx_state_q   <= rx_state_d;
            rx_ticks_q   <= rx_ticks_d;
            rx_bits_q    <= rx_bits_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_q     <= rx_par_d;
            rx_word_q    <= rx_word_d;
            rx_push_q    <= rx_push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_write),
        .wdata   (tx_data),
        .pop     (tx_pop),
        .head    (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level)
    );

    uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push_q),
        .wdata   (rx_word_q),
        .pop     (rx_read),
        .head    (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_level)
    );

    assign uart_tx       = tx_line_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_parity_err = parity_err_q;
    assign rx_overrun    = overrun_q;
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: loopback framing, parity, frame error,
// overrun, start-glitch rejection, divider timing and asynchronous reset.

module tb_uart_fifo_core;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] div = '0;
    logic          parity_en = 1'b0, parity_odd = 1'b0;
    logic          uart_rx, uart_tx;
    logic [DB-1:0] tx_data = '0;
    logic          tx_write = 1'b0, tx_full;
    logic [LW-1:0] tx_level, rx_level;
    logic [DB-1:0] rx_data;
    logic          rx_read = 1'b0, rx_empty;
    logic          rx_frame_err, rx_parity_err, rx_overrun;
    logic          err_clear = 1'b0;
    logic          loop_en = 1'b0, rx_drv = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int first_rx;
    int t_cyc;

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_core #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW), .LW(LW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .div           (div),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .tx_data       (tx_data),
        .tx_write      (tx_write),
        .tx_full       (tx_full),
        .tx_level      (tx_level),
        .rx_data       (rx_data),
        .rx_read       (rx_read),
        .rx_empty      (rx_empty),
        .rx_level      (rx_level),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .err_clear     (err_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic write_tx(input logic [DB-1:0] d);
        tx_data  = d;
        tx_write = 1'b1;
        @(negedge clk);
        tx_write = 1'b0;
    endtask

    task automatic pop_rx();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    task automatic wait_tx_start(input int bound);
        int i = 0;
        while (uart_tx !== 1'b0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        check("tx_start_seen", {31'b0, uart_tx === 1'b0}, 32'd1);
    endtask

    task automatic wait_rx_word(input int bound);
        int i = 0;
        while (rx_empty !== 1'b0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        check("rx_word_arrived", {31'b0, rx_empty === 1'b0}, 32'd1);
    endtask

    // Entered on the first negedge showing the start bit; bits[k] is frame bit k.
    task automatic capture_tx(input string name, input logic [15:0] bits, input int nbits,
                              input int bit_cycles);
        int   bad;
        logic mid;
        t_cyc    = -1;
        first_rx = -1;
        for (int k = 0; k < nbits; k++) begin
            bad = 0;
            mid = 1'bx;
            for (int c = 0; c < bit_cycles; c++) begin
                if (k != 0 || c != 0)
                    @(negedge clk);
                t_cyc++;
                if (uart_tx !== bits[k])
                    bad++;
                if (c == bit_cycles / 2)
                    mid = uart_tx;
                if (rx_empty === 1'b0 && first_rx < 0)
                    first_rx = t_cyc;
            end
            check($sformatf("%s_bit%0d", name, k), {31'b0, mid}, {31'b0, bits[k]});
            check($sformatf("%s_hold%0d", name, k), bad, 32'd0);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic has_par, input logic par,
                           input logic stop, input int bit_cycles);
        logic [10:0] f;
        int          n;
        f = has_par ? {stop, par, d, 1'b0} : {1'b0, stop, d, 1'b0};
        n = has_par ? 11 : 10;
        for (int k = 0; k < n; k++) begin
            rx_drv = f[k];
            repeat (bit_cycles) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset values while reset_n is held low.
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_rx_empty", {31'b0, rx_empty}, 32'd1);
        check("rst_tx_full", {31'b0, tx_full}, 32'd0);
        check("rst_levels", {tx_level, rx_level}, 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Loopback 8N1, div = 0: 0xA5 -> 0,1,0,1,0,0,1,0,1,1.
        loop_en = 1'b1;
        write_tx(8'hA5);
        wait_tx_start(20);
        capture_tx("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16);
        check("a5_latency_le163", {31'b0, (first_rx >= 0 && first_rx <= 163)}, 32'd1);
        check("a5_rx_data", rx_data, 32'hA5);
        check("a5_rx_level", rx_level, 32'd1);
        check("a5_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);
        pop_rx();
        check("a5_popped_empty", {31'b0, rx_empty}, 32'd1);
        check("a5_popped_level", rx_level, 32'd0);

        // Odd parity, 0x03 has two ones -> parity bit 1.
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        write_tx(8'h03);
        wait_tx_start(20);
        capture_tx("p03", {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 16);
        wait_rx_word(40);
        check("p03_rx_data", rx_data, 32'h03);
        check("p03_no_parity_err", {31'b0, rx_parity_err}, 32'd0);
        pop_rx();

        // Injected frame with wrong parity: flag set, word still pushed.
        loop_en = 1'b0;
        send_rx(8'h03, 1'b1, 1'b0, 1'b1, 16);
        wait_rx_word(40);
        check("perr_rx_data", rx_data, 32'h03);
        check("perr_flag", {31'b0, rx_parity_err}, 32'd1);
        check("perr_frame_clean", {31'b0, rx_frame_err}, 32'd0);
        pop_rx();
        pulse_clear();
        check("perr_cleared", {31'b0, rx_parity_err}, 32'd0);

        // Frame error: stop bit sampled low, word discarded.
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 16);
        repeat (60) @(negedge clk);
        check("ferr_flag", {31'b0, rx_frame_err}, 32'd1);
        check("ferr_rx_empty", {31'b0, rx_empty}, 32'd1);
        check("ferr_no_parity", {31'b0, rx_parity_err}, 32'd0);
        pulse_clear();
        check("ferr_cleared", {31'b0, rx_frame_err}, 32'd0);

        // div = 3: a 5-tick low pulse is rejected as a start glitch.
        div = 16'd3;
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_rx_empty", {31'b0, rx_empty}, 32'd1);
        check("glitch_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);

        // div = 3 loopback: 64-cycle bits, 0x3C received intact.
        loop_en = 1'b1;
        write_tx(8'h3C);
        wait_tx_start(40);
        capture_tx("d3c", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 64);
        wait_rx_word(100);
        check("d3c_rx_data", rx_data, 32'h3C);
        pop_rx();

        // Overrun: five words into a 4-deep FIFO with no reads.
        div     = '0;
        loop_en = 1'b0;
        for (int i = 1; i <= 5; i++)
            send_rx(8'(i), 1'b0, 1'b0, 1'b1, 16);
        repeat (20) @(negedge clk);
        check("ovr_level", rx_level, 32'd4);
        check("ovr_flag", {31'b0, rx_overrun}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_read%0d", i), rx_data, i);
            pop_rx();
        end
        check("ovr_drained_empty", {31'b0, rx_empty}, 32'd1);
        check("ovr_flag_sticky", {31'b0, rx_overrun}, 32'd1);

        // Two queued words; the second write coincides with the first pop.
        loop_en = 1'b1;
        write_tx(8'h81);
        write_tx(8'h7E);
        check("txq_level", tx_level, 32'd1);
        wait_rx_word(400);
        repeat (20) @(negedge clk);
        check("pre_rst_rx_level", rx_level, 32'd1);

        // Asynchronous reset mid-frame, checked before the next clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("arst_rx_empty", {31'b0, rx_empty}, 32'd1);
        check("arst_levels", {tx_level, rx_level}, 32'd0);
        check("arst_tx_full", {31'b0, tx_full}, 32'd0);
        check("arst_rx_data", rx_data, 32'd0);
        check("arst_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_idle_tx", {31'b0, uart_tx}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
